fm_stream_ctrl: RTL and testbench

//  Frame sequencer for the feature-map window wrapper. Per start pulse it walks one frame
//  of the on-chip FM buffer in raster order: pulses verticle_sync, drives mode_in, paces

---
 rtl/fm_stream_ctrl.sv | 155 +++++++++++++++
 tb/tb_fm_stream_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_stream_ctrl.sv
// Frame sequencer: per start, walks one raster frame of the FM buffer issuing one pixel read
// every INTERVAL cycles, then waits for the wrapper's output windows or an idle timeout.
module fm_stream_ctrl #(
    parameter int FM_WIDTH  = 56,
    parameter int FM_HEIGHT = 56,
    parameter int INTERVAL  = 8,
    parameter int TIMEOUT   = 1024,
    parameter int ADDR_W    = 12,
    parameter int DIM_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              hold,
    input  logic              cfg_mode,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              data_in_valid,
    output logic              verticle_sync,
    output logic              mode_in,
    input  logic              data_out_valid,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              cfg_err
);
    localparam int CNT_W  = 2 * DIM_W;
    localparam int PACE_W = (INTERVAL > 2) ? $clog2(INTERVAL) : 1;
    localparam int IDLE_W = $clog2(TIMEOUT) + 1;
    localparam logic [DIM_W-1:0]  MAX_W     = DIM_W'(FM_WIDTH);
    localparam logic [DIM_W-1:0]  MAX_H     = DIM_W'(FM_HEIGHT);
    localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(INTERVAL - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t             state;
    logic [PACE_W-1:0]  pace_cnt;
    logic [ADDR_W-1:0]  addr;
    logic [ADDR_W-1:0]  last_addr;
    logic [CNT_W-1:0]   expect_cnt;
    logic [CNT_W-1:0]   out_cnt;
    logic [IDLE_W-1:0]  idle_cnt;
    logic               to_flag;
    logic               mode_q;

    logic               cfg_ok;
    logic               win_pulse;
    logic [DIM_W-1:0]   half_w;
    logic [DIM_W-1:0]   half_h;
    logic [CNT_W-1:0]   frame_px;
    logic [CNT_W-1:0]   frame_win;
    logic [CNT_W-1:0]   out_cnt_nxt;

    assign cfg_ok = (cfg_width != '0) && (cfg_width <= MAX_W) &&
                    (cfg_height != '0) && (cfg_height <= MAX_H);
    assign half_w    = (cfg_width + DIM_W'(1)) >> 1;
    assign half_h    = (cfg_height + DIM_W'(1)) >> 1;
    assign frame_px  = CNT_W'(cfg_width) * CNT_W'(cfg_height);
    assign frame_win = CNT_W'(half_w) * CNT_W'(half_h);

    // out_cnt saturates at the expected count so surplus pulses are harmless
    assign win_pulse   = data_out_valid && (out_cnt != expect_cnt);
    assign out_cnt_nxt = out_cnt + CNT_W'(win_pulse);

    // abort suppresses the strobes in the cycle it is raised
    assign rd_en         = (state == S_STREAM) && (pace_cnt == '0) && !hold && !abort;
    assign verticle_sync = (state == S_SYNC) && !abort;
    assign done          = (state == S_DONE) && !abort;
    assign timeout       = done && to_flag;
    assign busy          = (state != S_IDLE);
    assign rd_addr       = addr;
    assign mode_in       = mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            pace_cnt      <= '0;
            addr          <= '0;
            last_addr     <= '0;
            expect_cnt    <= '0;
            out_cnt       <= '0;
            idle_cnt      <= '0;
            to_flag       <= 1'b0;
            mode_q        <= 1'b0;
            cfg_err       <= 1'b0;
            data_in_valid <= 1'b0;
        end else begin
            cfg_err       <= 1'b0;
            data_in_valid <= rd_en;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            state      <= S_SYNC;
                            mode_q     <= cfg_mode;
                            last_addr  <= ADDR_W'(frame_px - CNT_W'(1));
                            expect_cnt <= cfg_mode ? frame_win : frame_px;
                            out_cnt    <= '0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_SYNC: begin
                    pace_cnt <= '0;
                    addr     <= '0;
                    out_cnt  <= out_cnt_nxt;
                    state    <= S_STREAM;
                end
                S_STREAM: begin
                    out_cnt <= out_cnt_nxt;
                    if (!hold)
                        pace_cnt <= (pace_cnt == PACE_LAST) ? '0 : pace_cnt + PACE_W'(1);
                    if (rd_en) begin
                        addr <= addr + ADDR_W'(1);
                        if (addr == last_addr) begin
                            state    <= S_DRAIN;
                            idle_cnt <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    // idle_cnt = cycles elapsed since the last pulse (or since DRAIN entry)
                    out_cnt <= out_cnt_nxt;
                    if (out_cnt_nxt == expect_cnt) begin
                        state   <= S_DONE;
                        to_flag <= 1'b0;
                    end else if (data_out_valid) begin
                        idle_cnt <= IDLE_W'(1);
                    end else if (idle_cnt == IDLE_LAST) begin
                        state   <= S_DONE;
                        to_flag <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    mode_q <= 1'b0;
                    addr   <= '0;
                end
                default: state <= S_IDLE;
            endcase
            if (abort && (state != S_IDLE)) begin
                state  <= S_IDLE;
                mode_q <= 1'b0;
                addr   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fm_stream_ctrl.sv
// Bench for fm_stream_ctrl: config vector table, directed frame/abort/reset sequences and
// randomized frames checked against a frame-level reference model.
module tb_fm_stream_ctrl;
    localparam int INTERVAL = 8;
    localparam int TIMEOUT  = 1024;
    localparam int MAXC     = 4096;

    logic        clk = 1'b0;
    logic        rst, start, abort, hold, cfg_mode, data_out_valid;
    logic [5:0]  cfg_width, cfg_height;
    logic        rd_en, data_in_valid, verticle_sync, mode_in, busy, done, timeout, cfg_err;
    logic [11:0] rd_addr;

    int checks = 0;
    int fails  = 0;

    bit rec_rd[MAXC], rec_hold[MAXC], rec_div[MAXC], rec_vs[MAXC], rec_mode[MAXC];
    bit rec_busy[MAXC], rec_done[MAXC], rec_to[MAXC], rec_err[MAXC], rec_dov[MAXC];
    bit sched[MAXC];
    int rec_addr[MAXC];

    typedef struct {
        int w; int h; int m; int ab; int err; int bsy;
    } vec_t;
    vec_t tv[9];

    fm_stream_ctrl #(.INTERVAL(INTERVAL), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
        .cfg_mode(cfg_mode), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .rd_en(rd_en), .rd_addr(rd_addr), .data_in_valid(data_in_valid),
        .verticle_sync(verticle_sync), .mode_in(mode_in), .data_out_valid(data_out_valid),
        .busy(busy), .done(done), .timeout(timeout), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one frame starting in the current cycle (cycle 0) and checks it against the model.
    // kind: 0 wrapper answers every window, 1 answers every pixel, 2 withholds the last window.
    task automatic run_frame(input string tag, input int w, input int h, input int m,
                             input int hold_pct, input int hs, input int he,
                             input int dly_base, input int dly_jit, input int kind,
                             output int done_at, output int first_rd);
        int e, n, nresp, nsent, npix, nrec, t, bad, cnt, ref_c, exp_done, exp_to, d0, nh, prev;
        int rdc[$];
        bit fin, win;
        n = w * h;
        e = m ? ((w + 1) / 2) * ((h + 1) / 2) : n;
        nresp = (kind == 2) ? e - 1 : MAXC;
        nsent = 0; npix = 0; nrec = 0; fin = 0;
        done_at = -1; first_rd = -1;
        for (int c = 0; c < MAXC; c++) sched[c] = 0;
        for (int c = 0; c < MAXC && !fin; c++) begin
            start = (c == 0) || (done_at < 0 && $urandom_range(15) == 0);
            if (c == 0) begin
                cfg_width = 6'(w); cfg_height = 6'(h); cfg_mode = m[0];
            end else begin
                cfg_width = 6'($urandom_range(63)); cfg_height = 6'($urandom_range(63));
                cfg_mode = 1'($urandom_range(1));
            end
            hold = (c >= hs && c < he) || (int'($urandom_range(99)) < hold_pct);
            data_out_valid = sched[c];
            @(negedge clk);
            rec_rd[c] = rd_en; rec_hold[c] = hold; rec_div[c] = data_in_valid;
            rec_vs[c] = verticle_sync; rec_mode[c] = mode_in; rec_busy[c] = busy;
            rec_done[c] = done; rec_to[c] = timeout; rec_err[c] = cfg_err;
            rec_dov[c] = data_out_valid; rec_addr[c] = int'(rd_addr);
            nrec = c + 1;
            if (rd_en && first_rd < 0) first_rd = c;
            if (data_in_valid) begin
                win = (m == 0) || (((npix / w) % 2 == 0) && ((npix % w) % 2 == 0));
                if ((win || kind == 1) && nsent < nresp) begin
                    t = c + dly_base + int'($urandom_range(dly_jit));
                    while (t < MAXC - 1 && sched[t]) t++;
                    sched[t] = 1;
                    nsent++;
                end
                npix++;
            end
            if (done && done_at < 0) done_at = c;
            if (done_at >= 0 && c >= done_at + 2) fin = 1;
            @(posedge clk); #1;
        end
        start = 0; hold = 0; data_out_valid = 0;
        if (done_at < 0) begin
            chk({tag, "_done_seen"}, 0, 1);
            return;
        end
        for (int c = 0; c < nrec; c++) if (rec_rd[c]) rdc.push_back(c);
        chk({tag, "_rd_count"}, rdc.size(), n);
        bad = 0;
        foreach (rdc[i]) if (rec_addr[rdc[i]] != i) bad++;
        chk({tag, "_rd_addr_seq"}, bad, 0);
        bad = 0;
        for (int c = 0; c < nrec; c++) if (rec_rd[c] && rec_hold[c]) bad++;
        chk({tag, "_rd_during_hold"}, bad, 0);
        // non-held cycles between consecutive reads (first read: none after the sync cycle)
        bad = 0; prev = 1;
        foreach (rdc[i]) begin
            nh = 0;
            for (int c = prev + 1; c < rdc[i]; c++) if (!rec_hold[c]) nh++;
            if (nh != ((i == 0) ? 0 : INTERVAL - 1)) bad++;
            prev = rdc[i];
        end
        chk({tag, "_pacing"}, bad, 0);
        cnt = 0;
        for (int c = 0; c < nrec; c++) cnt += rec_vs[c];
        chk({tag, "_vsync_count"}, cnt, 1);
        chk({tag, "_vsync_at_1"}, rec_vs[1], 1);
        bad = 0;
        for (int c = 1; c < nrec; c++) if (rec_div[c] != rec_rd[c-1]) bad++;
        chk({tag, "_div_is_rd_delayed"}, bad, 0);
        bad = 0;
        for (int c = 1; c <= done_at; c++) if (rec_mode[c] != m[0] || !rec_busy[c]) bad++;
        chk({tag, "_mode_busy_in_frame"}, bad, 0);
        chk({tag, "_busy_after_done"}, rec_busy[done_at + 1], 0);
        cnt = 0; bad = 0;
        for (int c = 0; c < nrec; c++) begin cnt += rec_done[c]; bad += rec_err[c]; end
        chk({tag, "_done_pulses"}, cnt, 1);
        chk({tag, "_no_cfg_err"}, bad, 0);
        exp_done = -1; exp_to = 0;
        if (rdc.size() > 0) begin
            d0 = rdc[rdc.size() - 1] + 1;
            cnt = 0;
            for (int c = 1; c < d0; c++) cnt += rec_dov[c];
            ref_c = d0;
            for (int c = d0; c < nrec && exp_done < 0; c++) begin
                cnt += rec_dov[c];
                if (cnt >= e) exp_done = c + 1;
                else if (rec_dov[c]) ref_c = c;
                else if (c - ref_c == TIMEOUT - 1) begin exp_done = c + 1; exp_to = 1; end
            end
        end
        chk({tag, "_done_cycle"}, done_at, exp_done);
        chk({tag, "_timeout_flag"}, rec_to[done_at], exp_to);
    endtask

    initial begin
        int d, f, dcnt;
        tv[0] = '{0,  3,  0, 0, 1, 0};
        tv[1] = '{57, 3,  0, 0, 1, 0};
        tv[2] = '{4,  0,  0, 0, 1, 0};
        tv[3] = '{4,  57, 1, 0, 1, 0};
        tv[4] = '{63, 63, 0, 0, 1, 0};
        tv[5] = '{56, 57, 0, 0, 1, 0};
        tv[6] = '{1,  1,  0, 0, 0, 1};
        tv[7] = '{56, 56, 1, 0, 0, 1};
        tv[8] = '{3,  2,  1, 1, 0, 1};
        rst = 1; start = 0; abort = 0; hold = 0; cfg_mode = 0; data_out_valid = 0;
        cfg_width = 0; cfg_height = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_outs", int'({rd_en, data_in_valid, verticle_sync, mode_in, busy, done, timeout, cfg_err}), 0);
        chk("reset_rd_addr", int'(rd_addr), 0);
        @(posedge clk); #1;

        foreach (tv[i]) begin
            cfg_width = 6'(tv[i].w); cfg_height = 6'(tv[i].h); cfg_mode = tv[i].m[0];
            start = 1; abort = tv[i].ab[0];
            @(posedge clk); #1;
            start = 0; abort = 0;
            @(negedge clk);
            chk($sformatf("vec%0d_cfg_err", i), cfg_err, tv[i].err);
            chk($sformatf("vec%0d_busy", i), busy, tv[i].bsy);
            chk($sformatf("vec%0d_vsync", i), verticle_sync, tv[i].bsy);
            chk($sformatf("vec%0d_mode_in", i), mode_in, tv[i].bsy ? tv[i].m : 0);
            @(posedge clk); #1;
            if (tv[i].bsy) begin
                abort = 1;
                @(posedge clk); #1;
                abort = 0;
            end
            @(negedge clk);
            chk($sformatf("vec%0d_idle_after", i), int'({busy, cfg_err}), 0);
            @(posedge clk); #1;
        end

        run_frame("w4h3", 4, 3, 0, 0, -1, -1, 3, 0, 0, d, f);
        chk("w4h3_first_rd", f, 2);
        chk("w4h3_done_at", d, 95);
        run_frame("w5h5m1", 5, 5, 1, 0, -1, -1, 3, 0, 0, d, f);
        chk("w5h5m1_done_at", d, 199);
        run_frame("hold20", 4, 3, 0, 0, 30, 50, 3, 0, 0, d, f);
        chk("hold20_done_at", d, 115);
        run_frame("tmo", 2, 2, 0, 0, -1, -1, 10, 0, 2, d, f);
        chk("tmo_done_at", d, 29 + TIMEOUT);

        // abort right after the read of addr 6
        cfg_width = 4; cfg_height = 3; cfg_mode = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (49) @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_pre_rd_en", rd_en, 1);
        chk("abort_pre_addr", int'(rd_addr), 6);
        @(posedge clk); #1;
        abort = 1;
        @(negedge clk);
        chk("abort_rd_en_drops", rd_en, 0);
        chk("abort_inflight_div", data_in_valid, 1);
        @(posedge clk); #1;
        abort = 0;
        @(negedge clk);
        chk("abort_busy_next", busy, 0);
        chk("abort_div_once", data_in_valid, 0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            dcnt += int'(done) + int'(data_in_valid) + int'(rd_en);
        end
        chk("abort_quiet_after", dcnt, 0);
        @(posedge clk); #1;

        // synchronous reset in the middle of a stride-2 frame
        cfg_width = 5; cfg_height = 4; cfg_mode = 1; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (29) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_mid_outs", int'({rd_en, data_in_valid, verticle_sync, mode_in, busy, done, timeout, cfg_err}), 0);
        chk("rst_mid_rd_addr", int'(rd_addr), 0);
        @(posedge clk); #1;
        run_frame("after_rst", 4, 3, 0, 10, -1, -1, 2, 3, 0, d, f);

        for (int i = 0; i < 12; i++) begin
            int w, h, m, k;
            w = int'($urandom_range(9, 1));
            h = int'($urandom_range(9, 1));
            m = int'($urandom_range(1));
            k = (i % 4 == 2) ? 1 : (i % 4 == 3) ? 2 : 0;
            if (k == 1) m = 1;
            run_frame($sformatf("rnd%0d", i), w, h, m, (i % 2) ? 25 : 0, -1, -1,
                      int'($urandom_range(4, 1)), int'($urandom_range(6)), k, d, f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
